mem_arbiter: RTL and testbench

Shared-memory arbiter for the dual-core system. It sits between two icaches, two dcaches and the single-port RAM, and grants the RAM to one requester at a time. Dcaches have priority over icaches, and requesters of the same class share the RAM round-robin. A dcache grant is held across the two words of one block, so a miss fill or writeback is never interleaved with another requester's access.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-port RAM to two dcaches and two icaches, one at a time.
// Dcaches outrank icaches, each class is round-robin, and a dcache keeps its grant for one block.
module mem_arbiter #(
   parameter int         BLK_WORDS  = 2,
   parameter logic [1:0] RAM_FREE   = 2'd0,
   parameter logic [1:0] RAM_BUSY   = 2'd1,
   parameter logic [1:0] RAM_ACCESS = 2'd2,
   parameter logic [1:0] RAM_ERROR  = 2'd3
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [1:0]       iREN,
   input  logic [1:0][31:0] iaddr,
   output logic [1:0]       iwait,
   output logic [1:0][31:0] iload,
   input  logic [1:0]       dREN,
   input  logic [1:0]       dWEN,
   input  logic [1:0][31:0] daddr,
   input  logic [1:0][31:0] dstore,
   output logic [1:0]       dwait,
   output logic [1:0][31:0] dload,
   output logic             ramREN,
   output logic             ramWEN,
   output logic [31:0]      ramaddr,
   output logic [31:0]      ramstore,
   input  logic [31:0]      ramload,
   input  logic [1:0]       ramstate
);

   localparam int BEATS_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]         state;
   logic [1:0]         owner;   // {class, core}; class 1 is a dcache
   logic               dptr;
   logic               iptr;
   logic [BEATS_W-1:0] beats;
   logic [28:0]        blk;

   logic [1:0]  d_valid;
   logic        sel_valid;
   logic [1:0]  sel_owner;
   logic [31:0] sel_addr;

   logic        own_dc;
   logic        own_core;
   logic        own_valid;
   logic [31:0] own_addr;
   logic        own_ren;
   logic        own_wen;

   logic        drive;
   logic        ram_done;
   logic        done;
   logic        more_beats;

   assign d_valid = dREN | dWEN;

   // IDLE arbitration: the pointer names the preferred core, the other core wins if it is quiet.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      sel_valid = 1'b0;
      sel_owner = 2'b00;
      if (|d_valid) begin
         sel_valid = 1'b1;
         sel_owner = {1'b1, (d_valid[dptr] ? dptr : ~dptr)};
      end else if (|iREN) begin
         sel_valid = 1'b1;
         sel_owner = {1'b0, (iREN[iptr] ? iptr : ~iptr)};
      end
      sel_addr = sel_owner[1] ? daddr[sel_owner[0]] : iaddr[sel_owner[0]];
   end

   assign own_dc    = owner[1];
   assign own_core  = owner[0];
   assign own_valid = own_dc ? d_valid[own_core] : iREN[own_core];
   assign own_addr  = own_dc ? daddr[own_core] : iaddr[own_core];
   assign own_wen   = own_dc & dWEN[own_core];
   assign own_ren   = own_dc ? (dREN[own_core] & ~dWEN[own_core]) : 1'b1;

   // The owner may only keep driving while it stays inside the block it was granted for.
   assign drive = (state == GRANT) && own_valid &&
                  ((beats == '0) || (own_addr[31:3] == blk));

   always_comb begin
      ram_done = 1'b0;
      case (ramstate)
         RAM_ACCESS:                    ram_done = 1'b1;
         RAM_FREE, RAM_BUSY, RAM_ERROR: ram_done = 1'b0;
         default:                       ram_done = 1'b0;
      endcase
   end

   assign done       = drive & ram_done;
   assign more_beats = own_dc && ((int'(beats) + 1) < BLK_WORDS);

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 2'b11;
      dwait    = 2'b11;
      iload    = '0;
      dload    = '0;
      if (drive) begin
         ramREN   = own_ren;
         ramWEN   = own_wen;
         ramaddr  = own_addr;
         ramstore = own_dc ? dstore[own_core] : 32'h0;
      end
      if (done) begin
         if (own_dc) begin
            dwait[own_core] = 1'b0;
            if (own_ren)
               dload[own_core] = ramload;
         end else begin
            iwait[own_core] = 1'b0;
            iload[own_core] = ramload;
         end
      end
   end

   // NOTE: all state flops use non-blocking assignments so each samples the pre-edge values.
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         owner <= 2'b00;
         dptr  <= 1'b0;
         iptr  <= 1'b0;
         beats <= '0;
         blk   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  state <= GRANT;
                  owner <= sel_owner;
                  beats <= '0;
                  blk   <= sel_addr[31:3];
               end
            end
            GRANT: begin
               // Release (with or without an access) hands the class preference to the other core.
               if (!drive || (done && !more_beats)) begin
                  state <= IDLE;
                  if (own_dc)
                     dptr <= ~own_core;
                  else
                     iptr <= ~own_core;
               end else if (done) begin
                  beats <= beats + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus a dcache round-robin sequence.
module tb_mem_arbiter;

   localparam logic [1:0] RS_F = 2'd0;
   localparam logic [1:0] RS_B = 2'd1;
   localparam logic [1:0] RS_A = 2'd2;
   localparam logic [1:0] RS_E = 2'd3;

   logic             CLK;
   logic             nRST;
   logic [1:0]       iREN;
   logic [1:0][31:0] iaddr;
   logic [1:0]       iwait;
   logic [1:0][31:0] iload;
   logic [1:0]       dREN;
   logic [1:0]       dWEN;
   logic [1:0][31:0] daddr;
   logic [1:0][31:0] dstore;
   logic [1:0]       dwait;
   logic [1:0][31:0] dload;
   logic             ramREN;
   logic             ramWEN;
   logic [31:0]      ramaddr;
   logic [31:0]      ramstore;
   logic [31:0]      ramload;
   logic [1:0]       ramstate;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter u_dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One record per clock cycle. Both icaches see ia, both dcaches see da;
   // dstore[1] = ds and dstore[0] = ds ^ 0x0F0F0F0F so the two store lanes differ.
   // lm marks which load lanes must carry ramload: {iload1, iload0, dload1, dload0}.
   typedef struct {
      string       name;
      logic        rst;
      logic [1:0]  iren;
      logic [31:0] ia;
      logic [1:0]  dren;
      logic [1:0]  dwen;
      logic [31:0] da;
      logic [31:0] ds;
      logic [1:0]  rs;
      logic [31:0] rl;
      logic [1:0]  e_iw;
      logic [1:0]  e_dw;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_store;
      logic [3:0]  e_lm;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string n, input logic rst, input logic [1:0] iren,
                               input logic [31:0] ia, input logic [1:0] dren, input logic [1:0] dwen,
                               input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                               input logic [31:0] rl, input logic [1:0] e_iw, input logic [1:0] e_dw,
                               input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                               input logic [31:0] e_store, input logic [3:0] e_lm);
      vec_t v;
      v.name = n;  v.rst = rst;   v.iren = iren;   v.ia = ia;
      v.dren = dren; v.dwen = dwen; v.da = da;     v.ds = ds;
      v.rs = rs;   v.rl = rl;     v.e_iw = e_iw;   v.e_dw = e_dw;
      v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr;
      v.e_store = e_store; v.e_lm = e_lm;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      nRST      = v.rst;
      iREN      = v.iren;
      iaddr[0]  = v.ia;
      iaddr[1]  = v.ia;
      dREN      = v.dren;
      dWEN      = v.dwen;
      daddr[0]  = v.da;
      daddr[1]  = v.da;
      dstore[0] = v.ds ^ 32'h0F0F_0F0F;
      dstore[1] = v.ds;
      ramstate  = v.rs;
      ramload   = v.rl;
   endtask

   task automatic compare(input vec_t v);
      check({v.name, ".iwait"},    32'(iwait),    32'(v.e_iw));
      check({v.name, ".dwait"},    32'(dwait),    32'(v.e_dw));
      check({v.name, ".ramREN"},   32'(ramREN),   32'(v.e_ren));
      check({v.name, ".ramWEN"},   32'(ramWEN),   32'(v.e_wen));
      check({v.name, ".ramaddr"},  ramaddr,       v.e_addr);
      check({v.name, ".ramstore"}, ramstore,      v.e_store);
      check({v.name, ".dload0"},   dload[0],      v.e_lm[0] ? v.rl : 32'h0);
      check({v.name, ".dload1"},   dload[1],      v.e_lm[1] ? v.rl : 32'h0);
      check({v.name, ".iload0"},   iload[0],      v.e_lm[2] ? v.rl : 32'h0);
      check({v.name, ".iload1"},   iload[1],      v.e_lm[3] ? v.rl : 32'h0);
   endtask

   initial begin
      logic [31:0] alt_addr [2];
      int          grants;
      int          exp_core;

      nRST = 1'b0; iREN = '0; iaddr = '0; dREN = '0; dWEN = '0;
      daddr = '0; dstore = '0; ramstate = RS_F; ramload = '0;

      //                 name          rst iren ia           dren dwen da           ds            rs    rl            iw dw ren wen addr         store         lm
      tbl.push_back(mk("rst",         0, 2'd0, 32'h0,     2'd0,2'd0,32'h0,     32'h0,        RS_F, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      // core0 dcache single read at 0x100, ACCESS in the first driven cycle
      tbl.push_back(mk("s1_req",      1, 2'd0, 32'h0,     2'd1,2'd0,32'h100,   32'h0,        RS_A, 32'h1111_1111,3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s1_acc",      1, 2'd0, 32'h0,     2'd1,2'd0,32'h100,   32'h0,        RS_A, 32'h1111_1111,3, 2, 1, 0, 32'h100,   32'h0F0F_0F0F,4'b0001));
      tbl.push_back(mk("s1_drop",     1, 2'd0, 32'h0,     2'd0,2'd0,32'h0,     32'h0,        RS_A, 32'h1111_1111,3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s1_idle",     1, 2'd0, 32'h0,     2'd0,2'd0,32'h0,     32'h0,        RS_F, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      // core0 dcache block 0x200/0x204 with retries; icache1 waits throughout
      tbl.push_back(mk("s2_arb",      1, 2'd2, 32'h800,   2'd1,2'd0,32'h200,   32'h0,        RS_B, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s2_w0_busy",  1, 2'd2, 32'h800,   2'd1,2'd0,32'h200,   32'h0,        RS_B, 32'h0,        3, 3, 1, 0, 32'h200,   32'h0F0F_0F0F,4'b0000));
      tbl.push_back(mk("s2_w0_free",  1, 2'd2, 32'h800,   2'd1,2'd0,32'h200,   32'h0,        RS_F, 32'h0,        3, 3, 1, 0, 32'h200,   32'h0F0F_0F0F,4'b0000));
      tbl.push_back(mk("s2_w0_acc",   1, 2'd2, 32'h800,   2'd1,2'd0,32'h200,   32'h0,        RS_A, 32'hAAAA_0001,3, 2, 1, 0, 32'h200,   32'h0F0F_0F0F,4'b0001));
      tbl.push_back(mk("s2_w1_busy",  1, 2'd2, 32'h800,   2'd1,2'd0,32'h204,   32'h0,        RS_B, 32'h0,        3, 3, 1, 0, 32'h204,   32'h0F0F_0F0F,4'b0000));
      tbl.push_back(mk("s2_w1_err",   1, 2'd2, 32'h800,   2'd1,2'd0,32'h204,   32'h0,        RS_E, 32'h0,        3, 3, 1, 0, 32'h204,   32'h0F0F_0F0F,4'b0000));
      tbl.push_back(mk("s2_w1_acc",   1, 2'd2, 32'h800,   2'd1,2'd0,32'h204,   32'h0,        RS_A, 32'hAAAA_0002,3, 2, 1, 0, 32'h204,   32'h0F0F_0F0F,4'b0001));
      tbl.push_back(mk("s2_i_arb",    1, 2'd2, 32'h800,   2'd0,2'd0,32'h0,     32'h0,        RS_A, 32'hAAAA_0003,3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s2_i1_acc",   1, 2'd2, 32'h800,   2'd0,2'd0,32'h0,     32'h0,        RS_A, 32'hBBBB_0003,1, 3, 1, 0, 32'h800,   32'h0,        4'b1000));
      tbl.push_back(mk("s2_idle",     1, 2'd0, 32'h0,     2'd0,2'd0,32'h0,     32'h0,        RS_F, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      // core1 dcache with dREN and dWEN together: the write wins
      tbl.push_back(mk("s3_arb",      1, 2'd0, 32'h0,     2'd2,2'd2,32'h300,   32'hDEAD_BEEF,RS_B, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s3_busy",     1, 2'd0, 32'h0,     2'd2,2'd2,32'h300,   32'hDEAD_BEEF,RS_B, 32'h0,        3, 3, 0, 1, 32'h300,   32'hDEAD_BEEF,4'b0000));
      tbl.push_back(mk("s3_acc",      1, 2'd0, 32'h0,     2'd2,2'd2,32'h300,   32'hDEAD_BEEF,RS_A, 32'h5555_5555,3, 1, 0, 1, 32'h300,   32'hDEAD_BEEF,4'b0000));
      tbl.push_back(mk("s3_drop",     1, 2'd0, 32'h0,     2'd0,2'd0,32'h0,     32'h0,        RS_F, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s3_idle",     1, 2'd0, 32'h0,     2'd0,2'd0,32'h0,     32'h0,        RS_F, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      // core0 dcache finishes word 0 of 0x400, moves to 0x500: release, re-arbitrate, full block
      tbl.push_back(mk("s5_arb",      1, 2'd0, 32'h0,     2'd1,2'd0,32'h400,   32'h0,        RS_A, 32'h4444_0000,3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s5_w0",       1, 2'd0, 32'h0,     2'd1,2'd0,32'h400,   32'h0,        RS_A, 32'h4444_0000,3, 2, 1, 0, 32'h400,   32'h0F0F_0F0F,4'b0001));
      tbl.push_back(mk("s5_newblk",   1, 2'd0, 32'h0,     2'd1,2'd0,32'h500,   32'h0,        RS_A, 32'h4444_0001,3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s5_rearb",    1, 2'd0, 32'h0,     2'd1,2'd0,32'h500,   32'h0,        RS_A, 32'h4444_0002,3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s5_b_w0",     1, 2'd0, 32'h0,     2'd1,2'd0,32'h500,   32'h0,        RS_A, 32'h5555_0000,3, 2, 1, 0, 32'h500,   32'h0F0F_0F0F,4'b0001));
      tbl.push_back(mk("s5_b_w1",     1, 2'd0, 32'h0,     2'd1,2'd0,32'h504,   32'h0,        RS_A, 32'h5555_0004,3, 2, 1, 0, 32'h504,   32'h0F0F_0F0F,4'b0001));
      tbl.push_back(mk("s5_idle",     1, 2'd0, 32'h0,     2'd0,2'd0,32'h0,     32'h0,        RS_F, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      // reset lands while icache0 is retrying; the same request is served afterwards
      tbl.push_back(mk("s6_arb",      1, 2'd1, 32'h900,   2'd0,2'd0,32'h0,     32'h0,        RS_B, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s6_busy",     1, 2'd1, 32'h900,   2'd0,2'd0,32'h0,     32'h0,        RS_B, 32'h0,        3, 3, 1, 0, 32'h900,   32'h0,        4'b0000));
      tbl.push_back(mk("s6_rst",      0, 2'd1, 32'h900,   2'd0,2'd0,32'h0,     32'h0,        RS_B, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s6_rearb",    1, 2'd1, 32'h900,   2'd0,2'd0,32'h0,     32'h0,        RS_B, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));
      tbl.push_back(mk("s6_acc",      1, 2'd1, 32'h900,   2'd0,2'd0,32'h0,     32'h0,        RS_A, 32'h9999_0000,2, 3, 1, 0, 32'h900,   32'h0,        4'b0100));
      tbl.push_back(mk("s6_idle",     1, 2'd0, 32'h0,     2'd0,2'd0,32'h0,     32'h0,        RS_F, 32'h0,        3, 3, 0, 0, 32'h0,     32'h0,        4'b0000));

      for (int k = 0; k < tbl.size(); k++) begin
         @(posedge CLK);
         #1;
         apply(tbl[k]);
         @(negedge CLK);
         compare(tbl[k]);
      end

      // Both dcaches request continuously; each moves to a new block after its word completes.
      // dptr was cleared by the reset above, so grants must go 0, 1, 0, 1.
      alt_addr[0] = 32'h1000;
      alt_addr[1] = 32'h2000;
      grants      = 0;
      for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
         @(posedge CLK);
         #1;
         dREN     = 2'b11;
         dWEN     = 2'b00;
         daddr[0] = alt_addr[0];
         daddr[1] = alt_addr[1];
         ramstate = RS_A;
         ramload  = 32'hC000_0000 + 32'(cyc);
         @(negedge CLK);
         if (ramREN) begin
            exp_core = grants % 2;
            check($sformatf("alt%0d.dwait", grants), 32'(dwait), (exp_core == 0) ? 32'h2 : 32'h1);
            check($sformatf("alt%0d.ramaddr", grants), ramaddr, alt_addr[exp_core]);
            check($sformatf("alt%0d.dload", grants), dload[exp_core], ramload);
            alt_addr[exp_core] = alt_addr[exp_core] + 32'h8;
            grants++;
         end
      end
      check("alt.grant_count", 32'(grants), 32'd4);

      @(posedge CLK);
      #1;
      dREN = 2'b00;
      @(posedge CLK);
      #1;
      @(negedge CLK);
      check("end.dwait", 32'(dwait), 32'h3);
      check("end.ramREN", 32'(ramREN), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
